// File: rtl/mbox_pf_capture.sv
// Page-fail capture for the EBOX: latches the first MBOX fault and its VMA,
// drives the page-fail dispatch/hold, and sequences a bounded parity retry.
module mbox_pf_capture #(
  parameter int RETRY_LIMIT = 1
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic        csh_adr_par_err,
  input  logic        mb_par_err,
  input  logic        adr_par_err,
  input  logic        nxm_err,
  input  logic        sbus_err,
  input  logic        pf_ebox_handle,
  input  logic [8:0]  mbox_gate_vma,
  input  logic        ebox_t0_in,
  input  logic        mbox_resp_in,
  input  logic        err_clr,
  output logic [10:0] pf_disp,
  output logic        page_fail_hold,
  output logic        ebox_retry_req,
  output logic [8:0]  err_vma,
  output logic [4:0]  err_sticky,
  output logic        overrun
);

  localparam int CW = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(RETRY_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RETRY} state_t;

  state_t        state_q, state_d;
  logic [10:0]   pf_disp_q, pf_disp_d;
  logic [8:0]    err_vma_q, err_vma_d;
  logic [4:0]    err_sticky_q, err_sticky_d;
  logic          hold_q, hold_d;
  logic          retry_req_q, retry_req_d;
  logic          overrun_q, overrun_d;
  logic          retryable_q, retryable_d;
  logic [CW-1:0] retry_cnt_q, retry_cnt_d;

  logic [4:0]    err_vec;
  logic          fault;
  logic [10:0]   code;
  logic          code_retryable;

  assign err_vec = {nxm_err, adr_par_err, csh_adr_par_err, mb_par_err, sbus_err};
  assign fault   = (|err_vec) | pf_ebox_handle;

  // Errors always outrank the PAG request; only cache/MB parity may retry.
  always_comb begin
    code           = 11'o1760;
    code_retryable = 1'b0;
    if (nxm_err) begin
      code = 11'o1700;
    end else if (adr_par_err) begin
      code = 11'o1710;
    end else if (csh_adr_par_err) begin
      code           = 11'o1720;
      code_retryable = 1'b1;
    end else if (mb_par_err) begin
      code           = 11'o1730;
      code_retryable = 1'b1;
    end else if (sbus_err) begin
      code = 11'o1740;
    end
  end

  always_comb begin
    state_d      = state_q;
    pf_disp_d    = pf_disp_q;
    err_vma_d    = err_vma_q;
    hold_d       = hold_q;
    retry_req_d  = retry_req_q;
    retryable_d  = retryable_q;
    retry_cnt_d  = retry_cnt_q;
    // Set wins over a same-cycle clear for both sticky flags.
    err_sticky_d = (err_clr ? 5'b0 : err_sticky_q) | err_vec;
    overrun_d    = (err_clr ? 1'b0 : overrun_q) | ((state_q == S_HOLD) && fault);

    case (state_q)
      S_IDLE, S_RETRY: begin
        if (fault) begin
          state_d     = S_HOLD;
          hold_d      = 1'b1;
          retry_req_d = 1'b0;
          pf_disp_d   = code;
          err_vma_d   = mbox_gate_vma;
          retryable_d = code_retryable;
        end else if ((state_q == S_RETRY) && mbox_resp_in) begin
          state_d     = S_IDLE;
          retry_req_d = 1'b0;
          retry_cnt_d = '0;
        end
      end
      S_HOLD: begin
        if (ebox_t0_in) begin
          hold_d = 1'b0;
          if (retryable_q && (retry_cnt_q < LIMIT)) begin
            state_d     = S_RETRY;
            retry_req_d = 1'b1;
            if (retry_cnt_q != {CW{1'b1}}) retry_cnt_d = retry_cnt_q + 1'b1;
          end else begin
            state_d     = S_IDLE;
            retry_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        hold_d      = 1'b0;
        retry_req_d = 1'b0;
        retry_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state_q      <= S_IDLE;
      pf_disp_q    <= 11'o0000;
      err_vma_q    <= '0;
      err_sticky_q <= '0;
      hold_q       <= 1'b0;
      retry_req_q  <= 1'b0;
      overrun_q    <= 1'b0;
      retryable_q  <= 1'b0;
      retry_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pf_disp_q    <= pf_disp_d;
      err_vma_q    <= err_vma_d;
      err_sticky_q <= err_sticky_d;
      hold_q       <= hold_d;
      retry_req_q  <= retry_req_d;
      overrun_q    <= overrun_d;
      retryable_q  <= retryable_d;
      retry_cnt_q  <= retry_cnt_d;
    end
  end

  assign pf_disp        = pf_disp_q;
  assign page_fail_hold = hold_q;
  assign ebox_retry_req = retry_req_q;
  assign err_vma        = err_vma_q;
  assign err_sticky     = err_sticky_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_mbox_pf_capture.sv
// Directed bench for mbox_pf_capture: expected output snapshots are queued as
// each step is driven and popped when the registered result is sampled.
module tb_mbox_pf_capture;

  logic        clk;
  logic        CROBAR;
  logic        csh_adr_par_err, mb_par_err, adr_par_err, nxm_err, sbus_err;
  logic        pf_ebox_handle;
  logic [8:0]  mbox_gate_vma;
  logic        ebox_t0_in, mbox_resp_in, err_clr;
  logic [10:0] pf_disp;
  logic        page_fail_hold, ebox_retry_req;
  logic [8:0]  err_vma;
  logic [4:0]  err_sticky;
  logic        overrun;

  // {pf_disp, hold, retry_req, err_vma, err_sticky, overrun}
  localparam int W = 28;
  logic [W-1:0] exp_q[$];
  int vectors;
  int miscompares;

  mbox_pf_capture #(.RETRY_LIMIT(1)) dut (
    .clk(clk), .CROBAR(CROBAR),
    .csh_adr_par_err(csh_adr_par_err), .mb_par_err(mb_par_err),
    .adr_par_err(adr_par_err), .nxm_err(nxm_err), .sbus_err(sbus_err),
    .pf_ebox_handle(pf_ebox_handle), .mbox_gate_vma(mbox_gate_vma),
    .ebox_t0_in(ebox_t0_in), .mbox_resp_in(mbox_resp_in), .err_clr(err_clr),
    .pf_disp(pf_disp), .page_fail_hold(page_fail_hold),
    .ebox_retry_req(ebox_retry_req), .err_vma(err_vma),
    .err_sticky(err_sticky), .overrun(overrun)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle_inputs();
    csh_adr_par_err = 1'b0; mb_par_err = 1'b0; adr_par_err = 1'b0;
    nxm_err = 1'b0; sbus_err = 1'b0; pf_ebox_handle = 1'b0;
    ebox_t0_in = 1'b0; mbox_resp_in = 1'b0; err_clr = 1'b0;
  endtask

  // One active edge; returns at the following falling edge to sample.
  task automatic tick();
    @(negedge clk);
    idle_inputs();
  endtask

  // Scoreboard
  task automatic push(input logic [10:0] pf, input logic hold, input logic rr,
                      input logic [8:0] vma, input logic [4:0] st, input logic ov);
    exp_q.push_back({pf, hold, rr, vma, st, ov});
  endtask

  task automatic chk(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    obs = {pf_disp, page_fail_hold, ebox_retry_req, err_vma, err_sticky, overrun};
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      vectors++;
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed pf=%o hold=%b rr=%b vma=%o st=%b ov=%b expected pf=%o hold=%b rr=%b vma=%o st=%b ov=%b",
               tag, obs[27:17], obs[16], obs[15], obs[14:6], obs[5:1], obs[0],
               exp[27:17], exp[16], exp[15], exp[14:6], exp[5:1], exp[0]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle_inputs();
    mbox_gate_vma = 9'o000;
    CROBAR = 1'b1;
    repeat (3) @(negedge clk);
    CROBAR = 1'b0;
    push(11'o0000, 0, 0, 9'o000, 5'b00000, 0); chk("reset");

    // 1: nxm capture, freeze, release without retry
    nxm_err = 1'b1; mbox_gate_vma = 9'o777; tick();
    push(11'o1700, 1, 0, 9'o777, 5'b10000, 0); chk("t1_capture");
    mbox_gate_vma = 9'o000; tick();
    push(11'o1700, 1, 0, 9'o777, 5'b10000, 0); chk("t1_frozen");
    ebox_t0_in = 1'b1; tick();
    push(11'o1700, 0, 0, 9'o777, 5'b10000, 0); chk("t1_release");
    tick();
    push(11'o1700, 0, 0, 9'o777, 5'b10000, 0); chk("t1_no_retry");
    err_clr = 1'b1; tick();
    push(11'o1700, 0, 0, 9'o777, 5'b00000, 0); chk("t1_clear");

    // 2: mb_par retries once, second fault reaches the limit
    mb_par_err = 1'b1; mbox_gate_vma = 9'o042; tick();
    push(11'o1730, 1, 0, 9'o042, 5'b00010, 0); chk("t2_capture");
    ebox_t0_in = 1'b1; tick();
    push(11'o1730, 0, 1, 9'o042, 5'b00010, 0); chk("t2_retry");
    tick();
    push(11'o1730, 0, 1, 9'o042, 5'b00010, 0); chk("t2_retry_held");
    mb_par_err = 1'b1; mbox_gate_vma = 9'o055; tick();
    push(11'o1730, 1, 0, 9'o055, 5'b00010, 0); chk("t2_recapture");
    ebox_t0_in = 1'b1; tick();
    push(11'o1730, 0, 0, 9'o055, 5'b00010, 0); chk("t2_limit");
    tick();
    push(11'o1730, 0, 0, 9'o055, 5'b00010, 0); chk("t2_idle");
    err_clr = 1'b1; tick();
    push(11'o1730, 0, 0, 9'o055, 5'b00000, 0); chk("t2_clear");

    // 3: simultaneous faults, priority to csh_adr_par, retry ended by response
    sbus_err = 1'b1; csh_adr_par_err = 1'b1; pf_ebox_handle = 1'b1;
    mbox_gate_vma = 9'o100; tick();
    push(11'o1720, 1, 0, 9'o100, 5'b00101, 0); chk("t3_priority");
    ebox_t0_in = 1'b1; tick();
    push(11'o1720, 0, 1, 9'o100, 5'b00101, 0); chk("t3_retry");
    mbox_resp_in = 1'b1; tick();
    push(11'o1720, 0, 0, 9'o100, 5'b00101, 0); chk("t3_resp");
    err_clr = 1'b1; tick();
    push(11'o1720, 0, 0, 9'o100, 5'b00000, 0); chk("t3_clear");

    // 4: overrun while held, then clear racing a new sticky set
    adr_par_err = 1'b1; mbox_gate_vma = 9'o200; tick();
    push(11'o1710, 1, 0, 9'o200, 5'b01000, 0); chk("t4_capture");
    nxm_err = 1'b1; mbox_gate_vma = 9'o300; tick();
    push(11'o1710, 1, 0, 9'o200, 5'b11000, 1); chk("t4_overrun");
    ebox_t0_in = 1'b1; tick();
    push(11'o1710, 0, 0, 9'o200, 5'b11000, 1); chk("t4_release");
    err_clr = 1'b1; sbus_err = 1'b1; mbox_gate_vma = 9'o011; tick();
    push(11'o1740, 1, 0, 9'o011, 5'b00001, 0); chk("t4_clr_vs_set");
    ebox_t0_in = 1'b1; tick();
    push(11'o1740, 0, 0, 9'o011, 5'b00001, 0); chk("t4_sbus_release");
    err_clr = 1'b1; tick();
    push(11'o1740, 0, 0, 9'o011, 5'b00000, 0); chk("t4_clear");

    // 5: PAG request alone is not retryable
    pf_ebox_handle = 1'b1; mbox_gate_vma = 9'o123; tick();
    push(11'o1760, 1, 0, 9'o123, 5'b00000, 0); chk("t5_capture");
    ebox_t0_in = 1'b1; tick();
    push(11'o1760, 0, 0, 9'o123, 5'b00000, 0); chk("t5_release");
    tick();
    push(11'o1760, 0, 0, 9'o123, 5'b00000, 0); chk("t5_no_retry");

    // 6: asynchronous reset during RETRY, then a fresh retry episode
    mb_par_err = 1'b1; mbox_gate_vma = 9'o321; tick();
    push(11'o1730, 1, 0, 9'o321, 5'b00010, 0); chk("t6_capture");
    ebox_t0_in = 1'b1; tick();
    push(11'o1730, 0, 1, 9'o321, 5'b00010, 0); chk("t6_retry");
    #2 CROBAR = 1'b1;
    #1;
    push(11'o0000, 0, 0, 9'o000, 5'b00000, 0); chk("t6_async_reset");
    @(negedge clk);
    CROBAR = 1'b0;
    push(11'o0000, 0, 0, 9'o000, 5'b00000, 0); chk("t6_after_reset");
    mb_par_err = 1'b1; mbox_gate_vma = 9'o456; tick();
    push(11'o1730, 1, 0, 9'o456, 5'b00010, 0); chk("t6_recapture");
    ebox_t0_in = 1'b1; tick();
    push(11'o1730, 0, 1, 9'o456, 5'b00010, 0); chk("t6_retry_again");
    mbox_resp_in = 1'b1; tick();
    push(11'o1730, 0, 0, 9'o456, 5'b00010, 0); chk("t6_resp");

    // Final report
    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL leftover: %0d queued expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
